// File: rtl/tt_pkg.sv
// tt_pkg: shared widths, types and sweep states for the truth-table capture harness.
package tt_pkg;
    localparam int N_IN = 7;
    localparam int TT_W = 2 ** N_IN;
    typedef logic [TT_W-1:0] tt_t;
    typedef logic [N_IN-1:0] minterm_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;
    // Hex digit 0 of the signature covers minterms 127..124.
    function automatic logic [3:0] tt_to_hex(input tt_t t, input int unsigned d);
        return t[TT_W-1-4*d -: 4];
    endfunction
endpackage

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps all 128 minterms through a 7-input function, captures its truth table,
// and reports table, match flag and on-set count over a valid/ready handshake.
module tt_sweep_capture import tt_pkg::*; #(
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] exp_tt,
    output logic [6:0]   x_drv,
    input  logic         f_in,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] tt,
    output logic         match,
    output logic [7:0]   ones_cnt
);
    sweep_state_t state, state_nx;
    logic [7:0]   scnt;
    tt_t          exp_q;
    logic         sample;

    assign sample = (state == RUN) && !abort && (scnt == 8'(SETTLE - 1));

    always_comb begin
        state_nx = state;
        if (state == IDLE && start)
            state_nx = RUN;
        else if (state == RUN && abort)
            state_nx = IDLE;
        else if (sample && x_drv == 7'd127)
            state_nx = DONE;
        else if (state == DONE && res_valid && res_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // x_drv doubles as the minterm index; it parks at 127 once the sweep ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_drv     <= '0;
            scnt      <= '0;
            exp_q     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            tt        <= '0;
            match     <= 1'b0;
            ones_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    exp_q    <= exp_tt;
                    x_drv    <= '0;
                    scnt     <= '0;
                    busy     <= 1'b1;
                    tt       <= '0;
                    ones_cnt <= '0;
                end
                RUN: if (abort) begin
                    busy  <= 1'b0;
                    x_drv <= '0;
                    scnt  <= '0;
                end else if (sample) begin
                    tt[x_drv] <= f_in;
                    ones_cnt  <= ones_cnt + {7'd0, f_in};
                    scnt      <= '0;
                    if (x_drv != 7'd127) x_drv <= x_drv + 7'd1;
                end else begin
                    scnt <= scnt + 8'd1;
                end
                // First DONE cycle registers the comparison; the result is then offered.
                DONE: if (!res_valid) begin
                    res_valid <= 1'b1;
                    busy      <= 1'b0;
                    match     <= (tt == exp_q);
                end else if (res_ready) begin
                    res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: directed scoreboard bench for the truth-table sweep harness.
module tb_tt_sweep_capture;
    typedef struct {
        logic [127:0] tt;
        logic         m;
        logic [7:0]   ones;
        int           at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, abort, res_ready, f_in;
    logic [127:0] exp_tt;
    logic [6:0]   x_drv;
    logic         busy, res_valid, match;
    logic [127:0] tt;
    logic [7:0]   ones_cnt;
    logic         start1, abort1, res_ready1, f_in1;
    logic [127:0] exp_tt1;
    logic [6:0]   x_drv1;
    logic         busy1, res_valid1, match1;
    logic [127:0] tt1;
    logic [7:0]   ones_cnt1;
    int           sel;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    exp_t         q[$];
    exp_t         q1[$];

    localparam logic [127:0] TT_X0  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [127:0] TT_X6  = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
    localparam logic [127:0] TT_AND = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign f_in  = (sel == 0) ? x_drv[0] : (sel == 1) ? x_drv[6] : &x_drv;
    assign f_in1 = &x_drv1;

    tt_sweep_capture #(.SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
        .x_drv(x_drv), .f_in(f_in), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .tt(tt), .match(match), .ones_cnt(ones_cnt)
    );

    tt_sweep_capture #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .exp_tt(exp_tt1),
        .x_drv(x_drv1), .f_in(f_in1), .busy(busy1), .res_valid(res_valid1),
        .res_ready(res_ready1), .tt(tt1), .match(match1), .ones_cnt(ones_cnt1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares each rising res_valid against the oldest queued expectation.
    initial begin
        logic rv_prev, rv1_prev;
        exp_t e;
        rv_prev = 1'b0;
        rv1_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid && !rv_prev) begin
                if (q.size() == 0) chk("unexpected_res_valid", 1'b1, 1'b0);
                else begin
                    e = q.pop_front();
                    chk("tt", tt, e.tt);
                    chk("match", match, e.m);
                    chk("ones_cnt", ones_cnt, e.ones);
                    chk("res_valid_cycle", cyc, e.at);
                    chk("busy_at_valid", busy, 1'b0);
                end
            end
            if (res_valid1 && !rv1_prev) begin
                if (q1.size() == 0) chk("unexpected_res_valid1", 1'b1, 1'b0);
                else begin
                    e = q1.pop_front();
                    chk("tt1", tt1, e.tt);
                    chk("match1", match1, e.m);
                    chk("ones_cnt1", ones_cnt1, e.ones);
                    chk("res_valid1_cycle", cyc, e.at);
                end
            end
            rv_prev = res_valid;
            rv1_prev = res_valid1;
        end
    end

    task automatic run(input int s, input logic [127:0] exp, input logic [127:0] ett,
                       input logic em, input logic [7:0] eo);
        exp_t e;
        @(posedge clk);
        #1;
        sel = s;
        exp_tt = exp;
        start = 1'b1;
        e.tt = ett; e.m = em; e.ones = eo; e.at = cyc + 1 + 257;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_tt = '0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && q1.size() == 0 && !res_valid && !res_valid1 && !busy && !busy1) return;
        end
        chk("wait_idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x_drv"}, x_drv, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_tt"}, tt, 0);
        chk({tag, "_match"}, match, 0);
        chk({tag, "_ones_cnt"}, ones_cnt, 0);
    endtask

    initial begin
        exp_t e;
        logic [127:0] tt_hold;
        bit seen;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; res_ready = 1'b1; exp_tt = '0; sel = 0;
        start1 = 1'b0; abort1 = 1'b0; res_ready1 = 1'b1; exp_tt1 = '0;
        #22;
        chk_zero("reset");
        rst_n = 1'b1;

        run(0, TT_X0, TT_X0, 1'b1, 8'd64);
        wait_idle(400);
        run(1, 128'h0, TT_X6, 1'b0, 8'd64);
        wait_idle(400);

        @(posedge clk);
        #1;
        start1 = 1'b1;
        exp_tt1 = TT_AND;
        e.tt = TT_AND; e.m = 1'b1; e.ones = 8'd1; e.at = cyc + 1 + 129;
        q1.push_back(e);
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_idle(300);

        // Held result with consumer stalled and a stray start during DONE.
        res_ready = 1'b0;
        run(0, TT_X0, TT_X0, 1'b1, 8'd64);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = res_valid;
        end
        chk("stall_res_valid_seen", seen, 1'b1);
        tt_hold = tt;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(posedge clk);
            #1;
            chk("stall_res_valid", res_valid, 1'b1);
            chk("stall_tt", tt, tt_hold);
            chk("stall_busy", busy, 1'b0);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("handshake_drop", res_valid, 1'b0);
        chk("after_hs_x_drv", x_drv, 7'd127);
        repeat (5) @(posedge clk);
        #1;
        chk("done_start_ignored_busy", busy, 1'b0);
        chk("done_start_ignored_valid", res_valid, 1'b0);

        // Abort at minterm 40.
        @(posedge clk);
        #1;
        sel = 0;
        start = 1'b1;
        exp_tt = TT_X0;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (x_drv == 7'd40) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("abort_reach_40", seen, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_x_drv", x_drv, 0);
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_valid", res_valid, 1'b0);
        chk("abort_stays_idle", busy, 1'b0);
        run(1, TT_X6, TT_X6, 1'b1, 8'd64);
        wait_idle(400);

        // Asynchronous reset in the middle of a sweep.
        run(0, TT_X0, TT_X0, 1'b1, 8'd64);
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_zero("async_rst");
        #2;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_valid", res_valid, 1'b0);
        chk("post_rst_x_drv", x_drv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
